// File: rtl/vload_sequencer.sv
// Sequencer for the 128-bit vector temporary load register: splits a load into word reads.
// Optional strided element gathering is compiled in with VLOAD_STRIDE_EN.
module vload_sequencer #(
  parameter int STRIDE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  input  logic [4:0]          num_bytes_i,
  input  logic [2:0]          elem_bytes_i,
`ifdef VLOAD_STRIDE_EN
  input  logic [STRIDE_W-1:0] stride_i,
`endif
  output logic                busy_o,
  output logic                done_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic                clear_register_o,
  output logic                byte_enable_valid_o,
  output logic [3:0]          byte_enable_o,
  output logic                read_data_valid_o,
  output logic [6:0]          byte_select_o
);

  // state  | meaning
  // S_IDLE | waiting for start_i
  // S_REQ  | memory request held until granted
  // S_WAIT | waiting for read data of the granted request
  // S_DONE | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_total, r_loaded;
  logic [31:0] r_cur;
  logic [1:0]  w_off;
  logic [2:0]  w_room, w_n;
  logic [4:0]  w_run_left, w_loaded_nxt;
  logic [3:0]  w_mask_base, w_mask;

  assign w_off  = r_cur[1:0];
  assign w_room = 3'd4 - {1'b0, w_off};

`ifdef VLOAD_STRIDE_EN
  logic [2:0]  r_elem_bytes, r_elem_loaded;
  logic [31:0] r_elem_base;
  logic [4:0]  w_elem_left, w_total_left;
  logic        w_elem_done;

  assign w_total_left = r_total - r_loaded;
  assign w_elem_left  = {2'b00, r_elem_bytes - r_elem_loaded};
  assign w_run_left   = (w_elem_left < w_total_left) ? w_elem_left : w_total_left;
  assign w_elem_done  = (r_elem_loaded + w_n) == r_elem_bytes;
`else
  logic w_unused;
  assign w_run_left = r_total - r_loaded;
  assign w_unused   = ^{elem_bytes_i, (STRIDE_W > 0)};
`endif

  assign w_n          = ({2'b00, w_room} < w_run_left) ? w_room : w_run_left[2:0];
  assign w_loaded_nxt = r_loaded + {2'b00, w_n};

  always_comb begin
    case (w_n)
      3'd1:    w_mask_base = 4'b0001;
      3'd2:    w_mask_base = 4'b0011;
      3'd3:    w_mask_base = 4'b0111;
      3'd4:    w_mask_base = 4'b1111;
      default: w_mask_base = 4'b0000;
    endcase
  end
  assign w_mask = w_mask_base << w_off;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt         = r_state;
    done_o              = 1'b0;
    mem_req_o           = 1'b0;
    mem_addr_o          = 32'h0;
    clear_register_o    = 1'b0;
    byte_enable_valid_o = 1'b0;
    byte_enable_o       = 4'h0;
    read_data_valid_o   = 1'b0;
    byte_select_o       = 7'h0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          clear_register_o = 1'b1;
          w_state_nxt      = (num_bytes_i == 5'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o           = 1'b1;
        mem_addr_o          = {r_cur[31:2], 2'b00};
        byte_enable_o       = w_mask;
        byte_enable_valid_o = mem_gnt_i;
        if (mem_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        read_data_valid_o = mem_rvalid_i;
        byte_select_o     = {2'b00, r_loaded};
        if (mem_rvalid_i) w_state_nxt = (w_loaded_nxt == r_total) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_total  <= 5'd0;
      r_loaded <= 5'd0;
      r_cur    <= 32'h0;
`ifdef VLOAD_STRIDE_EN
      r_elem_bytes  <= 3'd0;
      r_elem_loaded <= 3'd0;
      r_elem_base   <= 32'h0;
`endif
    end else if (r_state == S_IDLE && start_i) begin
      r_total  <= (num_bytes_i > 5'd16) ? 5'd16 : num_bytes_i;
      r_loaded <= 5'd0;
      r_cur    <= base_addr_i;
`ifdef VLOAD_STRIDE_EN
      // Unsupported element sizes fall back to whole words so a request always makes progress.
      case (elem_bytes_i)
        3'd1:    r_elem_bytes <= 3'd1;
        3'd2:    r_elem_bytes <= 3'd2;
        default: r_elem_bytes <= 3'd4;
      endcase
      r_elem_loaded <= 3'd0;
      r_elem_base   <= base_addr_i;
`endif
    end else if (r_state == S_WAIT && mem_rvalid_i) begin
      r_loaded <= w_loaded_nxt;
`ifdef VLOAD_STRIDE_EN
      if (w_elem_done) begin
        r_cur         <= r_elem_base + 32'(stride_i);
        r_elem_base   <= r_elem_base + 32'(stride_i);
        r_elem_loaded <= 3'd0;
      end else begin
        r_cur         <= r_cur + {29'h0, w_n};
        r_elem_loaded <= r_elem_loaded + w_n;
      end
`else
      r_cur <= r_cur + {29'h0, w_n};
`endif
    end
  end

endmodule
